// File: rtl/mux_arb_pkg.sv
// Shared constants for the mux_arb_nx datapath selector: mode encodings,
// default sizing and an index-width helper.
package mux_arb_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    localparam int unsigned DEF_WIDTH    = 16;
    localparam int unsigned DEF_CHANNELS = 4;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: masked priority pick starting at ptr, falling back
// to the unmasked request vector so the search wraps modulo N.
module rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          any
);

    logic [N-1:0] mask;
    logic [N-1:0] masked;
    logic [N-1:0] pick;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            mask[i] = (i >= 32'(ptr));
        end
        masked = req & mask;
        pick   = (|masked) ? masked : req;

        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        if (en) begin
            // Descending scan so the lowest set bit is the last one written.
            for (int unsigned i = N; i > 0; i--) begin
                if (pick[i-1]) begin
                    grant_idx = PW'(i - 1);
                end
            end
            any = |req;
            if (any) begin
                grant[grant_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_nx.sv
// N-channel registered selector with valid/ready handshake; fixed-select or
// round-robin. Optional macro MUX_ARB_LOCK_EN adds a Lock input for bursts.
module mux_arb_nx
    import mux_arb_pkg::*;
#(
    parameter  int unsigned WIDTH    = DEF_WIDTH,
    parameter  int unsigned CHANNELS = DEF_CHANNELS,
    localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic [CHANNELS*WIDTH-1:0] InData,
    input  logic [CHANNELS-1:0]       InValid,
    output logic [CHANNELS-1:0]       InReady,
    input  logic [SEL_W-1:0]          S,
    input  logic                      Mode,
`ifdef MUX_ARB_LOCK_EN
    input  logic                      Lock,
`endif
    output logic [WIDTH-1:0]          OutputExit,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic [SEL_W-1:0]          OutSrc
);

    logic                load;
    logic                rr_mode;
    logic [SEL_W-1:0]    ptr;
    logic [SEL_W-1:0]    ptr_next;
    logic [CHANNELS-1:0] rr_grant;
    logic [SEL_W-1:0]    rr_idx;
    logic                rr_any;
    logic                fix_ok;
    logic [CHANNELS-1:0] grant_oh;
    logic [SEL_W-1:0]    grant_idx;
    logic                any_grant;
    logic                in_xfer;
    logic [WIDTH-1:0]    sel_data;

    assign rr_mode = (Mode == MODE_RR);

    rr_arbiter #(
        .N(CHANNELS)
    ) u_rr (
        .req       (InValid),
        .ptr       (ptr),
        .en        (rr_mode),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any       (rr_any)
    );

    always_comb begin
        load   = !OutValid || OutReady;
        // Out-of-range selects can only occur when CHANNELS is not a power of two.
        fix_ok = (32'(S) < CHANNELS) && InValid[S];

        grant_oh  = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        if (rr_mode) begin
            grant_oh  = rr_grant;
            grant_idx = rr_idx;
            any_grant = rr_any;
        end else if (fix_ok) begin
            grant_oh[S] = 1'b1;
            grant_idx   = S;
            any_grant   = 1'b1;
        end

        InReady = (!Reset && load && any_grant) ? grant_oh : '0;
        in_xfer = |InReady;

        sel_data = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (32'(grant_idx) == i) begin
                sel_data = InData[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ptr_next = ptr;
        if (in_xfer && rr_mode) begin
            ptr_next = (32'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + SEL_W'(1);
`ifdef MUX_ARB_LOCK_EN
            if (Lock) begin
                ptr_next = grant_idx;
            end
`endif
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            OutputExit <= '0;
            OutValid   <= 1'b0;
            OutSrc     <= '0;
            ptr        <= '0;
        end else begin
            ptr <= ptr_next;
            if (in_xfer) begin
                OutputExit <= sel_data;
                OutSrc     <= grant_idx;
                OutValid   <= 1'b1;
            end else if (OutReady) begin
                OutValid <= 1'b0;
            end
        end
    end

endmodule
